// File: rtl/sram_march_bist_if.sv
// sram_march_bist_if: single-port SRAM bus between the BIST controller and the macro.
interface sram_march_bist_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 2
) ();
    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (output csb0, web0, addr0, din0, input dout0);
    modport slave  (input csb0, web0, addr0, din0, output dout0);
endinterface

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- self-test controller for one 1rw SRAM port with first-failure capture.
module sram_march_bist #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [2:0]            fail_elem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_got,
    sram_march_bist_if.master     bus
);
    localparam int RL = READ_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic [2:0]            elem, n_elem;
    logic [ADDR_WIDTH-1:0] addr, n_addr;
    logic                  ph, n_ph;
    logic                  single, down, n_down, last_addr, addr_done, last_op, n_rd, mism, pend;
    logic [DATA_WIDTH-1:0] n_din, n_exp;

    logic                  pv  [RL+1];
    logic [2:0]            pel [RL+1];
    logic [ADDR_WIDTH-1:0] pa  [RL+1];
    logic [DATA_WIDTH-1:0] px  [RL+1];

    // elem/addr/ph describe the op currently on the bus; n_* is the op after it
    always_comb begin
        single    = elem == 3'd0 || elem == 3'd5;
        down      = elem == 3'd3 || elem == 3'd4;
        last_addr = down ? addr == '0 : addr == '1;
        addr_done = single || ph;
        last_op   = elem == 3'd5 && last_addr;
        n_ph      = !addr_done;
        n_elem    = addr_done && last_addr ? elem + 3'd1 : elem;
        n_down    = n_elem == 3'd3 || n_elem == 3'd4;
        n_addr    = !addr_done ? addr : last_addr ? {ADDR_WIDTH{n_down}} :
                    down ? addr - A_ONE : addr + A_ONE;
        n_rd      = n_elem != 3'd0 && !n_ph;
        n_din     = {DATA_WIDTH{n_elem == 3'd1 || n_elem == 3'd3}};
        n_exp     = {DATA_WIDTH{n_elem == 3'd2 || n_elem == 3'd4}};
        mism      = (state == RUN || state == DRAIN) && pv[RL] && (bus.dout0 !== px[RL]);
        pend      = 1'b0;
        for (int i = 0; i < RL; i++) pend = pend | pv[i];
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_elem <= '0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            elem      <= '0;
            addr      <= '0;
            ph        <= 1'b0;
            bus.csb0  <= 1'b1;
            bus.web0  <= 1'b1;
            bus.addr0 <= '0;
            bus.din0  <= '0;
            for (int i = 0; i <= RL; i++) begin
                pv[i]  <= 1'b0;
                pel[i] <= '0;
                pa[i]  <= '0;
                px[i]  <= '0;
            end
        end else begin
            for (int i = RL; i > 0; i--) begin
                pv[i]  <= pv[i-1];
                pel[i] <= pel[i-1];
                pa[i]  <= pa[i-1];
                px[i]  <= px[i-1];
            end
            pv[0] <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    fail      <= 1'b0;
                    fail_elem <= '0;
                    fail_addr <= '0;
                    fail_exp  <= '0;
                    fail_got  <= '0;
                    elem      <= '0;
                    addr      <= '0;
                    ph        <= 1'b0;
                    bus.csb0  <= 1'b0;
                    bus.web0  <= 1'b0;
                    bus.addr0 <= '0;
                    bus.din0  <= '0;
                    for (int i = 0; i <= RL; i++) pv[i] <= 1'b0;
                end
                RUN, DRAIN: if (mism) begin
                    state     <= DONE;
                    fail      <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    bus.csb0  <= 1'b1;
                    bus.web0  <= 1'b1;
                    fail_elem <= pel[RL];
                    fail_addr <= pa[RL];
                    fail_exp  <= px[RL];
                    fail_got  <= bus.dout0;
                    for (int i = 0; i <= RL; i++) pv[i] <= 1'b0;
                end else if (state == DRAIN) begin
                    if (!pend) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end else if (last_op) begin
                    state    <= DRAIN;
                    bus.csb0 <= 1'b1;
                    bus.web0 <= 1'b1;
                end else begin
                    elem      <= n_elem;
                    addr      <= n_addr;
                    ph        <= n_ph;
                    bus.web0  <= n_rd;
                    bus.addr0 <= n_addr;
                    bus.din0  <= n_din;
                    pv[0]     <= n_rd;
                    pel[0]    <= n_elem;
                    pa[0]     <= n_addr;
                    px[0]     <= n_exp;
                end
            endcase
        end
    end
endmodule
